// File: rtl/audio_feature_extract_if.sv
// Stream bundle between the FFT front end, audio_feature_extract and the recognizer.
// master: FFT source / recognizer side. slave: the feature extractor.
interface audio_feature_extract_if;
  logic signed [15:0] fft_re;
  logic signed [15:0] fft_im;
  logic               fft_valid;
  logic               fft_last;
  logic signed [15:0] feature_out;
  logic               feature_out_en;
  logic               busy;
  logic               frame_err;

  modport master (
    output fft_re, fft_im, fft_valid, fft_last,
    input  feature_out, feature_out_en, busy, frame_err
  );

  modport slave (
    input  fft_re, fft_im, fft_valid, fft_last,
    output feature_out, feature_out_en, busy, frame_err
  );
endinterface

// File: rtl/audio_feature_extract.sv
// audio_feature_extract: sums |re|+|im| over BAND_BINS-wide bands of each FFT frame,
// stores FRAME_NUM frames of band sums and then streams the whole feature vector
// frame-major. Build option: define AUDIO_FEAT_LOG_EN for a log2-style feature
// instead of the linear (band_sum >> 4, saturated) feature.
module audio_feature_extract #(
  parameter int FFT_LEN   = 256,
  parameter int BAND_NUM  = 16,
  parameter int BAND_BINS = 8,
  parameter int FRAME_NUM = 12
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  audio_feature_extract_if.slave  io
);

  localparam int DLEN      = BAND_NUM * FRAME_NUM;
  localparam int USED_BINS = BAND_NUM * BAND_BINS;
  localparam int BIN_W     = $clog2(FFT_LEN);
  localparam int SUB_W     = $clog2(BAND_BINS + 1);
  localparam int BAND_W    = $clog2(BAND_NUM + 1);
  localparam int FRM_W     = $clog2(FRAME_NUM + 1);
  localparam int ADDR_W    = $clog2(DLEN);
  localparam int CNT_W     = $clog2(DLEN + 1);

  localparam logic [BIN_W:0]    USED_CMP  = (BIN_W+1)'(USED_BINS);
  localparam logic [BIN_W-1:0]  BIN_LAST  = BIN_W'(FFT_LEN - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(BAND_BINS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(FRAME_NUM - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DLEN);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DLEN - 1);

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  // |x| widened to 17 bits so that -32768 maps to 32768 without wrapping.
  function automatic logic [16:0] abs17(input logic signed [15:0] x);
    logic signed [16:0] xe;
    xe = {x[15], x};
    return x[15] ? unsigned'(-xe) : unsigned'(xe);
  endfunction

  // Linear feature: band_sum / 16 clamped to the positive signed range.
  function automatic logic signed [15:0] lin_feat(input logic [19:0] s);
    logic [15:0] sh;
    sh = s[19:4];
    return (sh > 16'd32767) ? 16'sd32767 : signed'(sh);
  endfunction

  // Log feature: MSB position in the upper bits, the next 10 bits below it as mantissa.
  function automatic logic signed [15:0] log_feat(input logic [19:0] s);
    logic [4:0]  p;
    logic [19:0] n;
    p = '0;
    for (int i = 0; i < 20; i++) begin
      if (s[i]) p = 5'(i);
    end
    n = s << (5'd19 - p);
    return (s == '0) ? 16'sd0 : signed'({1'b0, p, n[18:9]});
  endfunction

  function automatic logic signed [15:0] to_feature(input logic [19:0] s);
`ifdef AUDIO_FEAT_LOG_EN
    return log_feat(s);
`else
    return lin_feat(s);
`endif
  endfunction

  logic [0:0]         state_q, state_d;
  logic [FRM_W-1:0]   frame_q, frame_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [BAND_W-1:0]  band_q, band_d;
  logic [19:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic               in_en_q;
  logic               frame_err_q, frame_err_d;
  logic               rd_vld_p1_q, rd_vld_p1_d;
  logic               rd_last_p1_q, rd_last_p1_d;
  logic [19:0]        rd_data_p1_q;
  logic signed [15:0] feature_out_q, feature_out_d;
  logic               feature_out_en_q, feature_out_en_d;
  logic               out_last_p2_q, out_last_p2_d;

  logic [19:0]        mem [DLEN];
  logic               wr_en, rd_en;
  logic [ADDR_W-1:0]  wr_addr, rd_addr;
  logic [19:0]        wr_data, band_sum;
  logic [16:0]        mag;
  logic               beat, bin_used, bin_end;

  assign mag      = abs17(io.fft_re) + abs17(io.fft_im);
  assign beat     = in_en_q & io.fft_valid;
  assign bin_used = ({1'b0, bin_q} < USED_CMP);
  assign bin_end  = (bin_q == BIN_LAST);

  // Frame collection, framing checks and output sequencing.
  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    bin_d        = bin_q;
    sub_d        = sub_q;
    band_d       = band_q;
    acc_d        = acc_q;
    rd_cnt_d     = rd_cnt_q;
    frame_err_d  = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    rd_vld_p1_d  = 1'b0;
    rd_last_p1_d = 1'b0;
    band_sum     = ((sub_q == '0) ? 20'd0 : acc_q) + {3'd0, mag};
    wr_data      = band_sum;
    wr_addr      = ADDR_W'(frame_q) * ADDR_W'(BAND_NUM) + ADDR_W'(band_q);
    rd_addr      = ADDR_W'(rd_cnt_q);

    case (state_q)
      ST_ACC: begin
        if (beat) begin
          if (bin_used) begin
            acc_d = band_sum;
            if (sub_q == SUB_LAST) begin
              wr_en  = 1'b1;
              sub_d  = '0;
              band_d = band_q + BAND_W'(1);
            end else begin
              sub_d = sub_q + SUB_W'(1);
            end
          end
          if (io.fft_last && bin_end) begin
            bin_d  = '0;
            sub_d  = '0;
            band_d = '0;
            if (frame_q == FRM_LAST) begin
              frame_d = '0;
              state_d = ST_OUT;
            end else begin
              frame_d = frame_q + FRM_W'(1);
            end
          end else if (io.fft_last || bin_end) begin
            // Misframed input: restart the same frame slot from bin 0.
            frame_err_d = 1'b1;
            bin_d       = '0;
            sub_d       = '0;
            band_d      = '0;
          end else begin
            bin_d = bin_q + BIN_W'(1);
          end
        end
      end
      ST_OUT: begin
        if (beat && io.fft_last) frame_err_d = 1'b1;
        if (rd_cnt_q != CNT_DONE) begin
          rd_en        = 1'b1;
          rd_vld_p1_d  = 1'b1;
          rd_last_p1_d = (rd_cnt_q == CNT_LAST);
          rd_cnt_d     = rd_cnt_q + CNT_W'(1);
        end
        // Stay in OUT until the last feature is actually on the output.
        if (out_last_p2_q) begin
          state_d  = ST_ACC;
          rd_cnt_d = '0;
        end
      end
      default: state_d = ST_ACC;
    endcase

    // ---- stage p1 -> p2: RAM read data converted to a feature ----
    feature_out_d    = rd_vld_p1_q ? to_feature(rd_data_p1_q) : 16'sd0;
    feature_out_en_d = rd_vld_p1_q;
    out_last_p2_d    = rd_last_p1_q;
  end

  // Feature RAM: band-sum writes during ACC, registered reads during OUT (stage p0 -> p1).
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_p1_q <= mem[rd_addr];
  end

  // Control and output registers; in_en_q delays input acceptance by one edge after reset release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q          <= ST_ACC;
      frame_q          <= '0;
      bin_q            <= '0;
      sub_q            <= '0;
      band_q           <= '0;
      acc_q            <= '0;
      rd_cnt_q         <= '0;
      in_en_q          <= 1'b0;
      frame_err_q      <= 1'b0;
      rd_vld_p1_q      <= 1'b0;
      rd_last_p1_q     <= 1'b0;
      feature_out_q    <= '0;
      feature_out_en_q <= 1'b0;
      out_last_p2_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      frame_q          <= frame_d;
      bin_q            <= bin_d;
      sub_q            <= sub_d;
      band_q           <= band_d;
      acc_q            <= acc_d;
      rd_cnt_q         <= rd_cnt_d;
      in_en_q          <= 1'b1;
      frame_err_q      <= frame_err_d;
      rd_vld_p1_q      <= rd_vld_p1_d;
      rd_last_p1_q     <= rd_last_p1_d;
      feature_out_q    <= feature_out_d;
      feature_out_en_q <= feature_out_en_d;
      out_last_p2_q    <= out_last_p2_d;
    end
  end

  assign io.feature_out    = feature_out_q;
  assign io.feature_out_en = feature_out_en_q;
  assign io.busy           = (state_q == ST_OUT);
  assign io.frame_err      = frame_err_q;

endmodule
